// File: rtl/imem_axi_rd_slave_pkg.sv
// Shared types for the instruction-memory AXI-lite read responder: response codes,
// FSM encoding, address map defaults and the random-delay LFSR step.
package imem_axi_rd_slave_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_CAPT,
        ST_RESP
    } state_e;

    localparam logic [31:0] DEF_BASE_ADDR  = 32'h8000_0000;
    localparam logic [31:0] DEF_SIZE_BYTES = 32'h0800_0000;

    // Wide enough for LATENCY (max 15) plus up to 3 random extra cycles
    localparam int CNT_W = 5;

    localparam logic [7:0] LFSR_SEED = 8'hA5;

    // Fibonacci step for x^8+x^6+x^5+x^4+1
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

endpackage

// File: rtl/imem_ar_buf.sv
// One-entry AR holding register: address, response class and extra delay of a posted fetch.
// Push and pop are never requested together (push needs !full, pop needs full).
module imem_ar_buf
    import imem_axi_rd_slave_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  resp_e             push_resp,
    input  logic [1:0]        push_xtra,
    input  logic              pop,
    output logic              full,
    output logic [ADDR_W-1:0] addr,
    output resp_e             resp,
    output logic [1:0]        xtra
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 1'b0;
            addr <= '0;
            resp <= RESP_OKAY;
            xtra <= 2'b00;
        end else begin
            if (push) begin
                full <= 1'b1;
                addr <= push_addr;
                resp <= push_resp;
                xtra <= push_xtra;
            end else if (pop) begin
                full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/imem_axi_rd_slave.sv
// AXI-lite AR/R responder for instruction memory with programmable latency and a one-entry AR buffer.
// Define IMEM_RAND_DELAY_EN to add 0..3 LFSR-driven extra wait cycles per request.
module imem_axi_rd_slave
    import imem_axi_rd_slave_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 64,
    parameter int                LATENCY    = 1,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(DEF_BASE_ADDR),
    parameter logic [ADDR_W-1:0] SIZE_BYTES = ADDR_W'(DEF_SIZE_BYTES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ARVALID,
    output logic              ARREADY,
    input  logic [ADDR_W-1:0] ARADDR,
    output logic              RVALID,
    input  logic              RREADY,
    output logic [DATA_W-1:0] RDATA,
    output logic [1:0]        RRESP,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W:0] BASE_X = {1'b0, BASE_ADDR};
    localparam logic [ADDR_W:0] SIZE_X = {1'b0, SIZE_BYTES};

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  cur_addr_q, addr_d;
    resp_e              cur_resp_q, resp_d;
    logic               rvalid_q, rvalid_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    resp_e              rresp_q, rresp_d;

    logic               ar_fire;
    logic [ADDR_W:0]    addr_x, off_x;
    resp_e              new_resp;
    logic [1:0]         new_xtra;

    logic               buf_push, buf_pop, buf_full;
    logic [ADDR_W-1:0]  buf_addr;
    resp_e              buf_resp;
    logic [1:0]         buf_xtra;

    function automatic logic [CNT_W-1:0] cnt_init(input logic [1:0] x);
        return CNT_W'(LATENCY) + CNT_W'(x);
    endfunction

    assign ARREADY = !rst && !buf_full;
    assign ar_fire = ARVALID && ARREADY;

    // Range check in ADDR_W+1 bits so BASE+SIZE near the top of the map cannot wrap
    assign addr_x = {1'b0, ARADDR};
    assign off_x  = addr_x - BASE_X;
    always_comb begin
        new_resp = RESP_OKAY;
        if (addr_x < BASE_X || off_x >= SIZE_X)
            new_resp = RESP_DECERR;
        else if (ARADDR[1:0] != 2'b00)
            new_resp = RESP_SLVERR;
    end

`ifdef IMEM_RAND_DELAY_EN
    logic [7:0] lfsr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            lfsr_q <= LFSR_SEED;
        else if (ar_fire)
            lfsr_q <= lfsr_next(lfsr_q);
    end

    assign new_xtra = lfsr_q[1:0];
`else
    assign new_xtra = 2'b00;
`endif

    imem_ar_buf #(.ADDR_W(ADDR_W)) u_ar_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (buf_push),
        .push_addr (ARADDR),
        .push_resp (new_resp),
        .push_xtra (new_xtra),
        .pop       (buf_pop),
        .full      (buf_full),
        .addr      (buf_addr),
        .resp      (buf_resp),
        .xtra      (buf_xtra)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cur_addr_q <= '0;
            cur_resp_q <= RESP_OKAY;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_addr_q <= addr_d;
            cur_resp_q <= resp_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = cur_addr_q;
        resp_d   = cur_resp_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        buf_push = 1'b0;
        buf_pop  = 1'b0;
        mem_ren  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ar_fire) begin
                    state_d = ST_WAIT;
                    addr_d  = ARADDR;
                    resp_d  = new_resp;
                    cnt_d   = cnt_init(new_xtra);
                end
            end
            ST_WAIT: begin
                buf_push = ar_fire;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    mem_ren = (cur_resp_q == RESP_OKAY);
                    state_d = ST_CAPT;
                end
            end
            ST_CAPT: begin
                buf_push = ar_fire;
                rdata_d  = (cur_resp_q == RESP_OKAY) ? mem_rdata : '0;
                rvalid_d = 1'b1;
                rresp_d  = cur_resp_q;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                if (RREADY) begin
                    rvalid_d = 1'b0;
                    if (buf_full) begin
                        buf_pop = 1'b1;
                        state_d = ST_WAIT;
                        addr_d  = buf_addr;
                        resp_d  = buf_resp;
                        cnt_d   = cnt_init(buf_xtra);
                    end else if (ar_fire) begin
                        // Keep IDLE's empty-buffer invariant: a fetch arriving on the
                        // closing handshake starts directly instead of being parked
                        state_d = ST_WAIT;
                        addr_d  = ARADDR;
                        resp_d  = new_resp;
                        cnt_d   = cnt_init(new_xtra);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    buf_push = ar_fire;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign RVALID    = rvalid_q;
    assign RDATA     = rdata_q;
    assign RRESP     = rresp_q;
    assign mem_raddr = {cur_addr_q[ADDR_W-1:3], 3'b000};

endmodule

// File: doc/imem_axi_rd_slave.md
Name: imem_axi_rd_slave

Overview:
AXI-lite read-channel responder (AR + R) in front of the instruction memory. It serves fetch requests from the front-end read master and drives a synchronous SRAM-style backend port. A programmable access latency emulates slow memory. A one-entry AR holding buffer lets the master post the next fetch address while the current response is pending. Out-of-range and misaligned addresses return error responses without touching memory.

Parameters:
ADDR_W, 32, AR address width (matches MemAddrBus)
DATA_W, 64, R data width (matches MemDataBus)
LATENCY, 1, wait cycles inserted between request acceptance and the backend read (0..15)
BASE_ADDR, 32'h80000000, first byte address of the instruction memory
SIZE_BYTES, 32'h08000000, memory size in bytes; valid range is BASE_ADDR .. BASE_ADDR+SIZE_BYTES-1

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
ARVALID  in  1  read address valid, from the master
ARREADY  out  1  read address ready
ARADDR  in  ADDR_W  read byte address
RVALID  out  1  read data valid
RREADY  in  1  master accepts read data
RDATA  out  DATA_W  read data
RRESP  out  2  2'b00 OKAY, 2'b10 SLVERR (misaligned), 2'b11 DECERR (out of range)
mem_ren  out  1  backend read strobe, one cycle long
mem_raddr  out  ADDR_W  backend address: ARADDR with the low 3 bits cleared
mem_rdata  in  DATA_W  backend data, valid in the cycle after mem_ren

Behaviour:
- Reset (asynchronous, any time): FSM goes to IDLE; RVALID=0; RDATA=0; RRESP=00; mem_ren=0; mem_raddr=0; AR buffer empty; latency counter=0. ARREADY=0 while rst=1.
- FSM states and transitions:
  - IDLE: AR handshake moves to WAIT, latches the address, loads cnt=LATENCY.
  - WAIT: if cnt!=0, decrement. If cnt==0, assert mem_ren (only when the response is OKAY), then move to CAPT.
  - CAPT: latch RDATA = mem_rdata for OKAY, or 0 for errors. Set RVALID=1, load RRESP. Move to RESP.
  - RESP: hold RDATA, RRESP and RVALID stable until RVALID&RREADY. On that handshake: if the buffer is full, go to WAIT with the buffered address; otherwise go to IDLE.
- Latency: an AR handshake on edge E gives RVALID=1 after edge E+LATENCY+2. The R handshake is counted on the edge where RVALID&RREADY is sampled.
- ARREADY = !rst & !buf_full, combinational. In IDLE the buffer is always empty, so the address goes straight to WAIT. In WAIT, CAPT and RESP an accepted address goes into the buffer.
- Buffer drain and refill in the same cycle: ARREADY=0 during the drain cycle. A new address can be accepted from the next cycle on.
- Classification is done at acceptance and stored with the address:
  - out of range (addr<BASE_ADDR or addr-BASE_ADDR>=SIZE_BYTES) -> DECERR
  - otherwise addr[1:0]!=0 -> SLVERR
  - otherwise OKAY
  - DECERR takes priority. Error responses have the same timing as OKAY, never pulse mem_ren, and return RDATA=0.
- RDATA carries the whole 64-bit doubleword; lane selection is the master's job.
- Range arithmetic is done in ADDR_W+1 bits, so BASE_ADDR+SIZE_BYTES overflow cannot wrap.
- RREADY held high continuously: back-to-back responses are allowed, with at most one response in flight and one pending.
- ARVALID dropped without a handshake: no effect.

Optional Feature:
IMEM_RAND_DELAY_EN:
- Defined: an 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1, reset seed 8'hA5) advances once per accepted request. The wait count loaded is cnt = LATENCY + lfsr[1:0], giving 0..3 extra cycles.
- Undefined: no LFSR, and cnt = LATENCY exactly.

Decomposition:
- Shared defines/package: RRESP codes (OKAY, SLVERR, DECERR), FSM state encoding (IDLE, WAIT, CAPT, RESP), and the default BASE_ADDR.
- Natural sub-module: imem_ar_buf, the one-entry address-plus-resp-class holding register with push/pop/full.

Test Plan:
- LATENCY=1, ARADDR=32'h80000000 at edge 0, RREADY=1, backend returns 64'h00000013_00000093:
  - mem_ren high in the cycle after edge 1, with mem_raddr=32'h80000000
  - RVALID=1 after edge 3, RDATA=64'h0000001300000093, RRESP=00
  - RVALID=0 after edge 4
- RREADY=0 for 5 cycles after RVALID rises:
  - RDATA and RRESP stable, RVALID stays 1
  - a second AR (32'h80000008) is accepted, then ARREADY=0
  - after RREADY=1, the second response arrives LATENCY+2 cycles after the first R handshake
- ARADDR=32'h7ffffffc:
  - RRESP=11, RDATA=0, mem_ren never asserted, same timing as OKAY
- ARADDR=32'h80000002:
  - RRESP=10, RDATA=0, no mem_ren
- Reset asserted in WAIT with a buffered request:
  - RVALID, mem_ren and ARREADY go to 0 immediately
  - after release, ARREADY=1 and the FSM is in IDLE
  - no stale response is produced
- With IMEM_RAND_DELAY_EN, 16 back-to-back fetches:
  - each AR-to-RVALID latency lies in [LATENCY+2, LATENCY+5]
  - the sequence of latencies matches a reference LFSR model seeded 8'hA5
